// File: rtl/ripemd160_round_group.sv
// rtl/ripemd160_round_group.sv - one 16-round RIPEMD-160 group (either line), RPC rounds per clock
// Loads a chaining state and message block, runs 16 rounds, holds the result until taken.
module ripemd160_round_group #(
  parameter int STAGE = 0,
  parameter int LINE  = 0,
  parameter int RPC   = 1
) (
  input  logic         clk_p_i,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [511:0] block,
  input  logic [159:0] state_in,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [159:0] ans,
  output logic [511:0] o_block
);

  if (STAGE < 0 || STAGE > 4) begin : gen_bad_stage
    $error("ripemd160_round_group: STAGE must be 0..4");
  end
  if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : gen_bad_rpc
    $error("ripemd160_round_group: RPC must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, ROUNDS, DONE} state_t;

  localparam int SIDX = (STAGE > 4) ? 4 : ((STAGE < 0) ? 0 : STAGE);
  localparam int TIDX = (LINE != 0) ? 5 + SIDX : SIDX;
  localparam int FSEL = (LINE != 0) ? 4 - SIDX : SIDX;

  // Word-select and rotate tables, one nibble per local round, round 0 in the top nibble.
  localparam logic [63:0] R_ALL [10] = '{
    64'h0123456789ABCDEF, 64'h74D1A6F3C0952EB8, 64'h3AE49F812706DB5C,
    64'h19BA08C4D37FE562, 64'h40597C2AE138B6FD,
    64'h5E7092B4D6F81A3C, 64'h6B370D5AEF8C4912, 64'hF5137E69B8C2A04D,
    64'h86413BF05C2D97AE, 64'hCFA4158762DE039B};
  localparam logic [63:0] S_ALL [10] = '{
    64'hBEFC5879BDEF6798, 64'h768DB97F7CF9B7DC, 64'hBD67E9DFE8D65C75,
    64'hBCEFEF989E56865C, 64'h9F5B68DC5CDEB856,
    64'h899BDFF5778BEEC6, 64'h9DF7C89B77C76FDB, 64'h97FB866ECD5EDD75,
    64'hF58BEE6E69C9C5F8, 64'h85C9C5E68D65FDBB};
  localparam logic [31:0] K_ALL [10] = '{
    32'h00000000, 32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hA953FD4E,
    32'h50A28BE6, 32'h5C4DD124, 32'h6D703EF3, 32'h7A6D76E9, 32'h00000000};

  localparam logic [63:0] R_TAB = R_ALL[TIDX];
  localparam logic [63:0] S_TAB = S_ALL[TIDX];
  localparam logic [31:0] K_RND = K_ALL[TIDX];

  function automatic logic [3:0] nib(input logic [63:0] tab, input logic [3:0] t);
    logic [63:0] sh;
    sh = tab << {t, 2'b00};
    return sh[63:60];
  endfunction

  // Rotate through a doubled word so no shift ever reaches 32.
  function automatic logic [31:0] rol(input logic [31:0] v, input logic [3:0] n);
    logic [63:0] dbl;
    dbl = {v, v} << n;
    return dbl[63:32];
  endfunction

  function automatic logic [31:0] bool_f(input logic [31:0] fx, input logic [31:0] fy,
                                         input logic [31:0] fz);
    case (FSEL)
      0:       return fx ^ fy ^ fz;
      1:       return (fx & fy) | (~fx & fz);
      2:       return (fx | ~fy) ^ fz;
      3:       return (fx & fz) | (fy & ~fz);
      default: return fx ^ (fy | ~fz);
    endcase
  endfunction

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] a, b, c, d, e;
  logic [31:0] x [16];
  logic [31:0] na, nb, nc, nd, ne, tv;
  logic        last_step;

  assign i_ready   = (state == IDLE);
  assign last_step = ({1'b0, cnt} + 5'(RPC)) == 5'd16;

  always_comb begin
    na = a;
    nb = b;
    nc = c;
    nd = d;
    ne = e;
    tv = '0;
    for (int k = 0; k < RPC; k++) begin
      tv = rol(na + bool_f(nb, nc, nd) + x[nib(R_TAB, cnt + 4'(k))] + K_RND,
               nib(S_TAB, cnt + 4'(k))) + ne;
      na = ne;
      ne = nd;
      nd = {nc[21:0], nc[31:22]};
      nc = nb;
      nb = tv;
    end
  end

  always_ff @(posedge clk_p_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      o_valid <= 1'b0;
      ans     <= '0;
      o_block <= '0;
      a       <= '0;
      b       <= '0;
      c       <= '0;
      d       <= '0;
      e       <= '0;
      for (int i = 0; i < 16; i++) x[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && i_ready) begin
            state           <= ROUNDS;
            cnt             <= '0;
            {a, b, c, d, e} <= state_in;
            o_block         <= block;
            for (int i = 0; i < 16; i++) x[i] <= block[32*i +: 32];
          end
        end
        ROUNDS: begin
          {a, b, c, d, e} <= {na, nb, nc, nd, ne};
          cnt             <= cnt + 4'(RPC);
          if (last_step) begin
            state   <= DONE;
            o_valid <= 1'b1;
            ans     <= {na, nb, nc, nd, ne};
          end
        end
        DONE: begin
          if (o_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ripemd160_round_group.sv
// tb/tb_ripemd160_round_group.sv - bench for ripemd160_round_group over all STAGE/LINE pairs, RPC 1/4/16
// Instance g: STAGE = g%5, LINE = (g/5)%2, RPC = {1,4,16}[g/10].
module tb_ripemd160_round_group;

  localparam int NI    = 30;
  localparam int NRAND = 200;
  localparam logic [159:0] H0 = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  localparam int RL [80] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
    7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
    3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
    1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
    4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13};
  localparam int RR [80] = '{
    5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
    6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
    15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
    8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
    12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11};
  localparam int SL [80] = '{
    11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
    7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
    11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
    11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
    9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6};
  localparam int SR [80] = '{
    8, 9, 9, 11, 13, 15, 15, 5, 7, 7, 8, 11, 14, 14, 12, 6,
    9, 13, 15, 7, 12, 8, 9, 11, 7, 7, 12, 7, 6, 15, 13, 11,
    9, 7, 15, 11, 8, 6, 6, 14, 12, 13, 5, 14, 13, 13, 7, 5,
    15, 5, 8, 11, 14, 14, 6, 14, 6, 9, 12, 9, 12, 5, 15, 8,
    8, 5, 12, 9, 12, 5, 14, 6, 8, 13, 6, 5, 15, 13, 11, 11};
  localparam logic [31:0] KL [5] = '{32'h00000000, 32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hA953FD4E};
  localparam logic [31:0] KR [5] = '{32'h50A28BE6, 32'h5C4DD124, 32'h6D703EF3, 32'h7A6D76E9, 32'h00000000};

  typedef struct {
    logic [31:0]  x0;
    logic [31:0]  x14;
    int           rsel;
    logic [159:0] digest;
  } kat_t;

  logic clk_p_i = 1'b0;
  logic rst_n;
  always #5 clk_p_i = ~clk_p_i;

  logic         iv     [NI];
  logic         iready [NI];
  logic [511:0] blk    [NI];
  logic [159:0] sti    [NI];
  logic         ovalid [NI];
  logic         oready [NI];
  logic [159:0] ans_w  [NI];
  logic [511:0] oblk   [NI];

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int RS = g / 10;
    ripemd160_round_group #(
      .STAGE(g % 5), .LINE((g / 5) % 2), .RPC(RS == 0 ? 1 : (RS == 1 ? 4 : 16))
    ) u_dut (
      .clk_p_i (clk_p_i), .rst_n (rst_n),
      .i_valid (iv[g]),   .i_ready (iready[g]),
      .block   (blk[g]),  .state_in (sti[g]),
      .o_valid (ovalid[g]), .o_ready (oready[g]),
      .ans     (ans_w[g]), .o_block (oblk[g])
    );
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int rpc_of(input int g);
    return (g / 10 == 0) ? 1 : ((g / 10 == 1) ? 4 : 16);
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] fgrp(input int grp, input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
    case (grp)
      0:       return x ^ y ^ z;
      1:       return (x & y) | (~x & z);
      2:       return (x | ~y) ^ z;
      3:       return (x & z) | (y & ~z);
      default: return x ^ (y | ~z);
    endcase
  endfunction

  // Straight transcription of the RIPEMD-160 round loop for rounds 16*stage .. 16*stage+15.
  function automatic logic [159:0] model(input int stage, input int line, input logic [511:0] blkv,
                                         input logic [159:0] st);
    logic [31:0] w [16];
    logic [31:0] ra, rb, rc, rd, re, t;
    int j;
    for (int i = 0; i < 16; i++) w[i] = blkv[32*i +: 32];
    {ra, rb, rc, rd, re} = st;
    for (int k = 0; k < 16; k++) begin
      j = 16 * stage + k;
      if (line == 0) t = rotl(ra + fgrp(j / 16, rb, rc, rd) + w[RL[j]] + KL[j / 16], SL[j]) + re;
      else           t = rotl(ra + fgrp(4 - j / 16, rb, rc, rd) + w[RR[j]] + KR[j / 16], SR[j]) + re;
      ra = re; re = rd; rd = rotl(rc, 10); rc = rb; rb = t;
    end
    return {ra, rb, rc, rd, re};
  endfunction

  function automatic logic [159:0] combine(input logic [159:0] h, input logic [159:0] l,
                                           input logic [159:0] r);
    logic [31:0] h0, h1, h2, h3, h4, al, bl, cl, dl, el, ar, br, cr, dr, er;
    {h0, h1, h2, h3, h4} = h;
    {al, bl, cl, dl, el} = l;
    {ar, br, cr, dr, er} = r;
    return {h1 + cl + dr, h2 + dl + er, h3 + el + ar, h4 + al + br, h0 + bl + cr};
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [159:0] rnd160();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Accept one block, scramble the inputs while busy, wait (bounded) for o_valid.
  task automatic run_one(input int idx, input logic [511:0] b, input logic [159:0] s,
                         output logic [159:0] res, output logic [511:0] ob, output int lat);
    @(negedge clk_p_i);
    check($sformatf("i_ready_idle[%0d]", idx), iready[idx], 1);
    iv[idx] = 1'b1; blk[idx] = b; sti[idx] = s;
    @(negedge clk_p_i);
    iv[idx] = 1'b0; blk[idx] = ~b; sti[idx] = ~s;
    lat = 0;
    while (!ovalid[idx] && lat < 40) begin
      @(negedge clk_p_i);
      lat++;
    end
    res = ans_w[idx];
    ob  = oblk[idx];
  endtask

  initial begin
    logic [159:0] a_res, exp_a, st, s, s2, digest;
    logic [511:0] ob, b, b2;
    logic [159:0] res [2];
    logic [159:0] exq [$];
    kat_t kats [2];
    int lat, cyc, n_acc, n_res, last_acc;
    logic saw;

    kats[0] = '{32'h00000080, 32'h00000000, 0, 160'hA585119C_54FCE9C5_97082861_48F5E87E_318D25B2};
    kats[1] = '{32'h80636261, 32'h00000018, 2, 160'hF708B28E_7A985DE0_8E4A049B_87B0C698_FC0B5AF1};

    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b1; blk[g] = rnd512(); sti[g] = rnd160(); oready[g] = 1'b1;
    end
    repeat (3) @(negedge clk_p_i);
    for (int g = 0; g < NI; g += 29) begin
      check($sformatf("rst_i_ready[%0d]", g), iready[g], 1);
      check($sformatf("rst_o_valid[%0d]", g), ovalid[g], 0);
      check($sformatf("rst_ans[%0d]", g), ans_w[g], 0);
      check($sformatf("rst_o_block[%0d]", g), oblk[g], 0);
    end
    for (int g = 0; g < NI; g++) iv[g] = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk_p_i);
    check("post_rst_ans", ans_w[0], 0);
    check("post_rst_o_valid", ovalid[0], 0);

    // First round from the standard IV with an all-zero block.
    @(negedge clk_p_i);
    iv[0] = 1'b1; blk[0] = '0; sti[0] = H0;
    @(negedge clk_p_i);
    iv[0] = 1'b0;
    @(negedge clk_p_i);
    check("round1_state", {gen_dut[0].u_dut.a, gen_dut[0].u_dut.b, gen_dut[0].u_dut.c,
                           gen_dut[0].u_dut.d, gen_dut[0].u_dut.e},
          160'hC3D2E1F0_1602F864_EFCDAB89_EB73FA62_10325476);
    lat = 1;
    while (!ovalid[0] && lat < 40) begin
      @(negedge clk_p_i);
      lat++;
    end
    check("round1_latency", lat, 16);
    check("round1_ans", ans_w[0], model(0, 0, '0, H0));

    // Known-answer digests by chaining all ten groups of one RPC setting.
    for (int v = 0; v < 2; v++) begin
      b = '0;
      b[31:0] = kats[v].x0;
      b[14*32 +: 32] = kats[v].x14;
      for (int ln = 0; ln < 2; ln++) begin
        st = H0;
        for (int sg = 0; sg < 5; sg++) begin
          run_one(kats[v].rsel * 10 + ln * 5 + sg, b, st, a_res, ob, lat);
          st = a_res;
        end
        res[ln] = st;
      end
      digest = combine(H0, res[0], res[1]);
      check($sformatf("kat%0d_digest", v), digest, kats[v].digest);
    end

    for (int g = 0; g < NI; g++) begin
      for (int n = 0; n < NRAND; n++) begin
        if (n == 0)      begin b = '1; s = '1; end
        else if (n == 1) begin b = '0; s = '0; end
        else             begin b = rnd512(); s = rnd160(); end
        run_one(g, b, s, a_res, ob, lat);
        check($sformatf("sweep_ans[%0d]", g), a_res, model(g % 5, (g / 5) % 2, b, s));
        check($sformatf("sweep_latency[%0d]", g), lat, 16 / rpc_of(g));
        check($sformatf("sweep_o_block[%0d]", g), ob, b);
      end
    end

    // Backpressure on instance 13 (STAGE 3, left, RPC 4).
    oready[13] = 1'b0;
    b = rnd512(); s = rnd160(); b2 = rnd512(); s2 = rnd160();
    exp_a = model(3, 0, b, s);
    run_one(13, b, s, a_res, ob, lat);
    check("bp_ans", a_res, exp_a);
    iv[13] = 1'b1; blk[13] = b2; sti[13] = s2;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_p_i);
      check("bp_o_valid_hold", ovalid[13], 1);
      check("bp_ans_hold", ans_w[13], exp_a);
      check("bp_i_ready_low", iready[13], 0);
      check("bp_o_block_hold", oblk[13], b);
    end
    oready[13] = 1'b1; iv[13] = 1'b0;
    @(negedge clk_p_i);
    check("bp_o_valid_drop", ovalid[13], 0);
    check("bp_i_ready_back", iready[13], 1);
    check("bp_second_ignored", ans_w[13], exp_a);

    // Back-to-back on instance 27 (STAGE 2, right, RPC 16).
    cyc = 0; n_acc = 0; n_res = 0; last_acc = -1;
    while (n_res < 8 && cyc < 200) begin
      @(negedge clk_p_i);
      cyc++;
      if (ovalid[27]) begin
        check("b2b_ans", ans_w[27], (exq.size() > 0) ? exq.pop_front() : 160'h0);
        n_res++;
      end
      if (iready[27] && n_acc < 8) begin
        if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, 3);
        last_acc = cyc;
        b = rnd512(); s = rnd160();
        iv[27] = 1'b1; blk[27] = b; sti[27] = s;
        exq.push_back(model(2, 1, b, s));
        n_acc++;
      end else if (n_acc >= 8) begin
        iv[27] = 1'b0;
      end
    end
    iv[27] = 1'b0;
    check("b2b_results", n_res, 8);

    // Reset pulse after nine rounds on instance 0.
    b = rnd512(); s = rnd160();
    @(negedge clk_p_i);
    iv[0] = 1'b1; blk[0] = b; sti[0] = s;
    @(negedge clk_p_i);
    iv[0] = 1'b0;
    repeat (9) @(negedge clk_p_i);
    check("mid_not_done", ovalid[0], 0);
    check("mid_o_block_loaded", oblk[0], b);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ans", ans_w[0], 0);
    check("mid_rst_o_block", oblk[0], 0);
    check("mid_rst_i_ready", iready[0], 1);
    check("mid_rst_state", {gen_dut[0].u_dut.a, gen_dut[0].u_dut.b, gen_dut[0].u_dut.c,
                            gen_dut[0].u_dut.d, gen_dut[0].u_dut.e}, 0);
    @(negedge clk_p_i);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk_p_i);
      if (ovalid[0]) saw = 1'b1;
    end
    check("mid_no_partial", saw, 0);
    b2 = rnd512(); s2 = rnd160();
    run_one(0, b2, s2, a_res, ob, lat);
    check("mid_fresh_ans", a_res, model(0, 0, b2, s2));
    check("mid_fresh_latency", lat, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
